// File: rtl/uart_receiver_pkg.sv
// Shared UART types: line configuration encodings, the receive FSM state
// type and the default oversampling rate.
package uart_receiver_pkg;

  localparam int OVERSAMPLE_RATE = 16;

  typedef enum logic [1:0] {DW_5BIT, DW_6BIT, DW_7BIT, DW_8BIT} data_width_e;
  typedef enum logic [1:0] {SB_1BIT, SB_15BIT, SB_RESERVED, SB_2BIT} stop_bits_e;
  typedef enum logic [1:0] {DISABLED_1, EVEN, DISABLED_2, ODD} parity_mode_e;

  typedef struct packed {
    data_width_e  data_width;
    stop_bits_e   stop_bits;
    parity_mode_e parity_mode;
  } uart_config_s;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE
  } uart_rx_fsm_e;

  // Data arrives LSB first into the top of the shift register, so a short
  // word sits in the upper bits and must be shifted down.
  function automatic logic [7:0] right_align(input logic [7:0] sh, input data_width_e dw);
    case (dw)
      DW_5BIT: return {3'b000, sh[7:3]};
      DW_6BIT: return {2'b00, sh[7:2]};
      DW_7BIT: return {1'b0, sh[7:1]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/uart_receiver_sync_ff.sv
// Multi-flop synchronizer for the asynchronous RX line; resets to the idle
// (high) level so reset never looks like a start bit. STAGES must be >= 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sync_q <= '1;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/parity/stop deframing with the
// line configuration frozen at start-bit detection.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_RATE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_tick_i,
  input  logic       rx_i,
  input  logic       rx_enable_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_i,
  input  logic [1:0] parity_mode_i,
  input  logic       rx_fifo_full_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       frame_error_o,
  output logic       parity_error_o,
  output logic       overrun_error_o,
  output logic       rx_idle_o
);

  localparam int               CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);

  uart_rx_fsm_e     state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  uart_config_s     cfg_q, cfg_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             stop_ext_q, stop_ext_d;
  logic             rx_sync, full_end, half_end, ext_end, push;
  logic [7:0]       rx_word;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (rx_sync)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= RX_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      cfg_q        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      stop_ext_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      cfg_q        <= cfg_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      stop_ext_q   <= stop_ext_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted up front so no branch
    // can leave it unassigned and infer a latch.
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    cfg_d        = cfg_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    stop_ext_d   = stop_ext_q;
    push         = 1'b0;
    rx_word      = right_align(shift_q, cfg_q.data_width);
    full_end     = ov_baud_tick_i && (tick_cnt_q == FULL_LAST);
    half_end     = ov_baud_tick_i && (tick_cnt_q == HALF_LAST);
    ext_end      = (cfg_q.stop_bits == SB_15BIT) ? half_end : full_end;

    if (ov_baud_tick_i) tick_cnt_d = tick_cnt_q + CNT_W'(1);

    unique case (state_q)
      RX_IDLE: begin
        tick_cnt_d            = '0;
        stop_ext_d            = 1'b0;
        cfg_d.data_width      = data_width_e'(data_width_i);
        cfg_d.stop_bits       = stop_bits_e'(stop_bits_i);
        cfg_d.parity_mode     = parity_mode_e'(parity_mode_i);
        if (rx_enable_i && !rx_sync) begin
          state_d      = RX_START;
          bit_cnt_d    = '0;
          shift_d      = '0;
          parity_err_d = 1'b0;
          frame_err_d  = 1'b0;
        end
      end
      RX_START: if (half_end) begin
        tick_cnt_d = '0;
        state_d    = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (full_end) begin
        tick_cnt_d = '0;
        shift_d    = {rx_sync, shift_q[7:1]};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(cfg_q.data_width) + 3'd4)
          state_d = cfg_q.parity_mode[0] ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (full_end) begin
        tick_cnt_d   = '0;
        parity_err_d = ((^rx_word) ^ rx_sync) != cfg_q.parity_mode[1];
        state_d      = RX_STOP;
      end
      RX_STOP: begin
        // stop_ext_q marks the optional half or full second stop period
        if (!stop_ext_q && full_end) begin
          tick_cnt_d = '0;
          if (!rx_sync) frame_err_d = 1'b1;
          if (cfg_q.stop_bits inside {SB_15BIT, SB_2BIT}) stop_ext_d = 1'b1;
          else                                              state_d    = RX_DONE;
        end else if (stop_ext_q && ext_end) begin
          tick_cnt_d = '0;
          if (cfg_q.stop_bits == SB_2BIT && !rx_sync) frame_err_d = 1'b1;
          state_d = RX_DONE;
        end
      end
      RX_DONE: begin
        push    = !rx_fifo_full_i;
        if (push) data_d = rx_word;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_done_o       = push;
  assign rx_data_o       = push ? rx_word : data_q;
  assign overrun_error_o = (state_q == RX_DONE) && rx_fifo_full_i;
  assign frame_error_o   = (state_q == RX_DONE) && frame_err_q;
  assign parity_error_o  = (state_q == RX_DONE) && parity_err_q;
  assign rx_idle_o       = (state_q == RX_IDLE);

endmodule
